fs_bist_controller: RTL and testbench
=====================================

// Module: fs_bist_controller
// PURPOSE
//  Built-in self-test sequencer for one full_subtractor instance. On start it drives all 8 input
//  vectors onto the subtractor, samples D/Bout after a settle delay and compares them with a
//  golden model. It then diagnoses which inputs (A, B, Bin) are stuck-at-0.
//  It sits between the system controller and the full_subtractor under test.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before sampling (>=1)
//  STOP_ON_FAIL   0  1: abort the sweep at the first mismatching vector and go straight to DIAG
// PORTS
//  clk          in   1   rising-edge clock (single clock domain)
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   1-cycle request; accepted only in IDLE or DONE
//  abort        in   1   synchronous abort; returns to IDLE from any state
//  dut_a        out  1   A driven to the full_subtractor (registered)
//  dut_b        out  1   B driven to the full_subtractor (registered)
//  dut_bin      out  1   Bin driven to the full_subtractor (registered)
//  dut_d        in   1   D returned by the full_subtractor
//  dut_bout     in   1   Bout returned by the full_subtractor
//  busy         out  1   high in APPLY/SAMPLE/DIAG
//  done         out  1   level; high in DONE until the next start, abort or rst
//  pass         out  1   valid with done; captured signature == GOLDEN_SIG
//  fail_map     out  8   bit k set = vector k mismatched
//  err_count    out  4   number of mismatching vectors, 0..8
//  diag_valid   out  1   valid with done; signature matched exactly one stuck-at-0 mask
//  fault_code   out  3   {A,B,Bin} stuck-at-0 mask; 3'b000 when pass
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; idx=0; resp_sig=0.
//  - Vector k (0..7): dut_a=k[2], dut_b=k[1], dut_bin=k[0].
//  - States: IDLE, APPLY, SAMPLE, DIAG, DONE.
//  - start in IDLE/DONE: clear fail_map, err_count, resp_sig, pass, diag_valid and fault_code.
//    Set idx=0, drive vector 0 and go to APPLY. start in any other state is ignored.
//  - APPLY: hold the vector for SETTLE_CYCLES cycles, then go to SAMPLE.
//  - SAMPLE (1 cycle): resp_sig[2k+1:2k] <= {dut_bout,dut_d}.
//    On a mismatch with the golden model: set fail_map[k] and increment err_count.
//    If k==7, or a mismatch occurs with STOP_ON_FAIL=1: go to DIAG.
//    Otherwise: idx++, drive the next vector, go to APPLY.
//  - DIAG (1 cycle): pass = (resp_sig==GOLDEN_SIG) and the full sweep completed.
//    Search masks m=0..7 in order; the lowest m with resp_sig==sa0_sig(m) gives fault_code=m
//    and diag_valid=1. With no match (or an early stop): diag_valid=0, fault_code=0.
//  - DONE: done=1, dut pins return to 0, results held.
//  - Latency at SETTLE_CYCLES=2: start sampled at cycle 0, samples at cycles 3+3k, DIAG at
//    cycle 25, done=1 from cycle 26. In general: start + 8*(SETTLE_CYCLES+1) + 2.
//  - abort (takes priority over start): go to IDLE, drop busy/done and clear results.
//  - rst mid-sweep: immediate return to reset values; no partial results are retained.
//  - err_count saturates at 8 by construction; no wrap.
// STRUCTURE
//  - fs_bist_pkg holds:
//    - state encoding (3-bit localparams)
//    - GOLDEN_SIG = 16'hC1BC
//    - function sa0_sig(mask): 16-bit signature of the subtractor with the masked inputs forced 0
//    - function fs_golden(a,b,bin): returns {bout,d}
//  - No sub-module: the FSM, idx counter, settle counter and signature register live in one
//    module. The full_subtractor is instantiated outside, by the integrator.
// TESTING
//  1 Fault-free full_subtractor, start -> done at cycle 26, pass=1, fail_map=8'h00,
//    err_count=0, diag_valid=1, fault_code=3'b000.
//  2 A forced 0 -> pass=0, resp_sig=16'hBCBC, fail_map=8'hF0, err_count=4, fault_code=3'b100,
//    diag_valid=1.
//  3 A, B and Bin all forced 0 -> fail_map=8'h9E, err_count=5, fault_code=3'b111, diag_valid=1.
//  4 Bout stuck-at-1 (unmodelled fault) -> fail_map=8'h71, err_count=4, diag_valid=0,
//    fault_code=0.
//  5 STOP_ON_FAIL=1 with A forced 0 -> stop after vector 4, fail_map=8'h10, err_count=1,
//    pass=0, diag_valid=0.
//  6 rst pulsed at cycle 10 -> outputs 0 in the same cycle. A start pulsed during busy, or
//    abort at cycle 12, gives IDLE with done=0. Restarting then runs a clean sweep.

Source files
------------

// File: rtl/fs_bist_pkg.sv
// ---------------------------------------------------------------------------
// fs_bist_pkg
// Shared definitions for the full_subtractor BIST controller:
//   - FSM state encoding (3-bit)
//   - GOLDEN_SIG: 16-bit response signature of a fault-free full_subtractor
//   - fs_golden(): reference full_subtractor returning {bout, d}
//   - sa0_sig():   signature of a subtractor whose masked inputs are stuck at 0
// Signature layout: bits [2k+1:2k] hold {bout, d} for vector k, and vector k
// drives {a, b, bin} = k[2:0].
// ---------------------------------------------------------------------------
package fs_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DIAG   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned SIG_W       = 2 * NUM_VECTORS;

  localparam logic [SIG_W-1:0] GOLDEN_SIG = 16'hC1BC;

  // Reference full subtractor: d = a - b - bin, bout = borrow out.
  function automatic logic [1:0] fs_golden(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
    return {bout, d};
  endfunction

  // mask = {A, B, Bin}; a set bit forces that subtractor input to 0.
  function automatic logic [SIG_W-1:0] sa0_sig(input logic [2:0] mask);
    logic [SIG_W-1:0] sig;
    logic [2:0]       v;
    sig = '0;
    for (int k = 0; k < NUM_VECTORS; k++) begin
      v = 3'(k) & ~mask;
      sig[2*k +: 2] = fs_golden(v[2], v[1], v[0]);
    end
    return sig;
  endfunction

endpackage

// File: rtl/fs_bist_controller.sv
// ---------------------------------------------------------------------------
// fs_bist_controller
// BIST sequencer for one externally instantiated full_subtractor. On start it
// steps through all 8 input vectors, holds each for SETTLE_CYCLES cycles,
// samples {bout, d} into a 16-bit response signature and compares each sample
// with the reference model. A final diagnosis cycle checks the signature
// against the fault-free value and against every stuck-at-0 input mask.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   STOP_ON_FAIL   1: abort the sweep at the first mismatching vector
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              1-cycle request, honoured in IDLE or DONE
//   abort              synchronous return to IDLE, results cleared
//   dut_a/b/bin  (out) registered vector driven to the subtractor
//   dut_d/bout   (in)  subtractor response
//   busy               high in APPLY / SAMPLE / DIAG
//   done               high in DONE
//   pass               signature matched GOLDEN_SIG over a full sweep
//   fail_map[7:0]      bit k = vector k mismatched
//   err_count[3:0]     number of mismatching vectors
//   diag_valid         signature matched a stuck-at-0 mask
//   fault_code[2:0]    lowest matching {A,B,Bin} stuck-at-0 mask
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, subtractor pins at 0
// APPLY  | vector idx driven, settle down-counter running
// SAMPLE | capture {bout,d} for vector idx, compare, advance or finish
// DIAG   | evaluate pass and search the stuck-at-0 signature table
// DONE   | results held, done high, pins at 0; start re-arms
// ---------------------------------------------------------------------------
module fs_bist_controller
  import fs_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_bin,
  input  logic       dut_d,
  input  logic       dut_bout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_map,
  output logic [3:0] err_count,
  output logic       diag_valid,
  output logic [2:0] fault_code
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Counter loads SETTLE_CYCLES-1 and APPLY leaves on terminal count 0, so
  // APPLY lasts exactly SETTLE_CYCLES cycles.
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [2:0]       vec_q, vec_d;
  logic [SIG_W-1:0] resp_sig, sig_d;
  logic [7:0]       fail_d;
  logic [3:0]       err_d;
  logic             pass_d;
  logic             dv_d;
  logic [2:0]       fc_d;
  logic             early_q, early_d;

  logic [1:0]       sample_rsp;
  logic [1:0]       expect_rsp;
  logic             mismatch;
  logic             diag_hit;
  logic [2:0]       diag_mask;

  assign sample_rsp = {dut_bout, dut_d};
  assign expect_rsp = fs_golden(idx_q[2], idx_q[1], idx_q[0]);
  assign mismatch   = (sample_rsp != expect_rsp);

  // Descending scan so the lowest matching mask is the one that sticks.
  always_comb begin
    diag_hit  = 1'b0;
    diag_mask = 3'b000;
    for (int m = 7; m >= 0; m--) begin
      if (resp_sig == sa0_sig(3'(m))) begin
        diag_hit  = 1'b1;
        diag_mask = 3'(m);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    sig_d    = resp_sig;
    fail_d   = fail_map;
    err_d    = err_count;
    pass_d   = pass;
    dv_d     = diag_valid;
    fc_d     = fault_code;
    early_d  = early_q;

    if (abort) begin
      state_d  = ST_IDLE;
      idx_d    = 3'd0;
      settle_d = '0;
      vec_d    = 3'd0;
      sig_d    = '0;
      fail_d   = 8'h00;
      err_d    = 4'd0;
      pass_d   = 1'b0;
      dv_d     = 1'b0;
      fc_d     = 3'b000;
      early_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_APPLY;
            idx_d    = 3'd0;
            settle_d = SETTLE_LOAD;
            vec_d    = 3'd0;
            sig_d    = '0;
            fail_d   = 8'h00;
            err_d    = 4'd0;
            pass_d   = 1'b0;
            dv_d     = 1'b0;
            fc_d     = 3'b000;
            early_d  = 1'b0;
          end
        end

        ST_APPLY: begin
          if (settle_q == '0) begin
            state_d = ST_SAMPLE;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end

        ST_SAMPLE: begin
          sig_d[{idx_q, 1'b0} +: 2] = sample_rsp;
          if (mismatch) begin
            fail_d[idx_q] = 1'b1;
            // At most 8 increments per sweep, so 4 bits never wrap.
            err_d = err_count + 4'd1;
          end
          if ((idx_q == 3'd7) || (mismatch && STOP_ON_FAIL)) begin
            state_d = ST_DIAG;
            early_d = (idx_q != 3'd7);
            vec_d   = 3'd0;
          end else begin
            state_d  = ST_APPLY;
            idx_d    = idx_q + 3'd1;
            vec_d    = idx_q + 3'd1;
            settle_d = SETTLE_LOAD;
          end
        end

        ST_DIAG: begin
          state_d = ST_DONE;
          pass_d  = (resp_sig == GOLDEN_SIG) && !early_q;
          // A truncated signature has unsampled zeros and would alias
          // onto stuck-at masks, so it never yields a diagnosis.
          if (diag_hit && !early_q) begin
            dv_d = 1'b1;
            fc_d = diag_mask;
          end else begin
            dv_d = 1'b0;
            fc_d = 3'b000;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      settle_q   <= '0;
      vec_q      <= 3'd0;
      resp_sig   <= '0;
      fail_map   <= 8'h00;
      err_count  <= 4'd0;
      pass       <= 1'b0;
      diag_valid <= 1'b0;
      fault_code <= 3'b000;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      vec_q      <= vec_d;
      resp_sig   <= sig_d;
      fail_map   <= fail_d;
      err_count  <= err_d;
      pass       <= pass_d;
      diag_valid <= dv_d;
      fault_code <= fc_d;
      early_q    <= early_d;
    end
  end

  assign dut_a   = vec_q[2];
  assign dut_b   = vec_q[1];
  assign dut_bin = vec_q[0];

  assign busy = (state_q == ST_APPLY) || (state_q == ST_SAMPLE) || (state_q == ST_DIAG);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fs_bist_controller.sv
// ---------------------------------------------------------------------------
// tb_fs_bist_controller
// Two controllers (STOP_ON_FAIL = 0 and 1) each drive their own behavioural
// full_subtractor with injectable faults: per-input stuck-at-0 and Bout
// stuck-at-1. Cycle n is the clock period ending with rising edge n; start is
// sampled at edge 0, so values observed #1 after edge n belong to cycle n+1.
// ---------------------------------------------------------------------------
module tb_fs_bist_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start_s;
  logic       abort;

  logic       dut_a, dut_b, dut_bin, dut_d, dut_bout;
  logic       busy, done, pass, diag_valid;
  logic [7:0] fail_map;
  logic [3:0] err_count;
  logic [2:0] fault_code;

  logic       s_a, s_b, s_bin, s_d, s_bout;
  logic       s_busy, s_done, s_pass, s_diag_valid;
  logic [7:0] s_fail_map;
  logic [3:0] s_err_count;
  logic [2:0] s_fault_code;

  logic [2:0] force0;
  logic       bout_sa1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic fa, fb, fbin, ga, gb, gbin;
  assign fa   = dut_a   & ~force0[2];
  assign fb   = dut_b   & ~force0[1];
  assign fbin = dut_bin & ~force0[0];
  assign dut_d    = fa ^ fb ^ fbin;
  assign dut_bout = ((~fa & fb) | (~fa & fbin) | (fb & fbin)) | bout_sa1;

  assign ga   = s_a   & ~force0[2];
  assign gb   = s_b   & ~force0[1];
  assign gbin = s_bin & ~force0[0];
  assign s_d    = ga ^ gb ^ gbin;
  assign s_bout = ((~ga & gb) | (~ga & gbin) | (gb & gbin)) | bout_sa1;

  fs_bist_controller #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_a(dut_a), .dut_b(dut_b), .dut_bin(dut_bin),
    .dut_d(dut_d), .dut_bout(dut_bout),
    .busy(busy), .done(done), .pass(pass), .fail_map(fail_map),
    .err_count(err_count), .diag_valid(diag_valid), .fault_code(fault_code)
  );

  fs_bist_controller #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) u_sof (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort),
    .dut_a(s_a), .dut_b(s_b), .dut_bin(s_bin),
    .dut_d(s_d), .dut_bout(s_bout),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail_map(s_fail_map),
    .err_count(s_err_count), .diag_valid(s_diag_valid), .fault_code(s_fault_code)
  );

  // Called #1 after an edge; start is seen at the next edge (edge 0).
  task automatic pulse_start(input bit sof);
    if (sof) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_s = 1'b0;
  endtask

  // Returns the cycle in which done is first observed high, -1 on timeout.
  task automatic wait_done(input bit sof, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 60 && cyc < 0; n++) begin
      @(posedge clk); #1;
      if ((sof ? s_done : done) === 1'b1) cyc = n + 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; abort = 1'b0;
    force0 = 3'b000; bout_sa1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, pass, diag_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, pass, diag_valid});
    end
    n_checks++;
    if ({fail_map, err_count, fault_code, dut_a, dut_b, dut_bin} !== 18'd0) begin
      n_fail++; $display("FAIL reset_results fail_map=%h err=%0d code=%b pins=%b",
                         fail_map, err_count, fault_code, {dut_a, dut_b, dut_bin});
    end
    n_checks++;
    if (u_dut.resp_sig !== 16'h0000) begin
      n_fail++; $display("FAIL reset_sig got=%h exp=0000", u_dut.resp_sig);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fault_free;
    int done_cyc;
    logic [2:0] expv;
    force0 = 3'b000; bout_sa1 = 1'b0;
    pulse_start(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL ff_busy got=%b exp=1", busy);
    end
    done_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_cyc < 0 && done === 1'b1) done_cyc = n + 1;
      // SAMPLE cycles are 3+3k; the vector on the pins must be k.
      if (((n + 1) % 3 == 0) && ((n + 1) <= 24)) begin
        expv = 3'((n + 1) / 3 - 1);
        n_checks++;
        if ({dut_a, dut_b, dut_bin} !== expv) begin
          n_fail++; $display("FAIL ff_vector cycle=%0d got=%b exp=%b", n + 1,
                             {dut_a, dut_b, dut_bin}, expv);
        end
      end
    end
    n_checks++;
    if (done_cyc != 26) begin
      n_fail++; $display("FAIL ff_latency done_cycle=%0d exp=26", done_cyc);
    end
    n_checks++;
    if ({pass, fail_map, err_count, diag_valid, fault_code} !== {1'b1, 8'h00, 4'd0, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL ff_result pass=%b map=%h err=%0d dv=%b code=%b exp 1/00/0/1/000",
                         pass, fail_map, err_count, diag_valid, fault_code);
    end
    n_checks++;
    if ({busy, dut_a, dut_b, dut_bin} !== 4'b0000) begin
      n_fail++; $display("FAIL ff_done_idle busy/pins got=%b exp=0000", {busy, dut_a, dut_b, dut_bin});
    end
  endtask

  // Starts from DONE of the previous test: results must be cleared by start.
  task automatic test_a_sa0;
    int done_cyc;
    force0 = 3'b100; bout_sa1 = 1'b0;
    pulse_start(1'b0);
    n_checks++;
    if ({pass, diag_valid, fail_map} !== 10'd0) begin
      n_fail++; $display("FAIL asa0_cleared pass=%b dv=%b map=%h exp 0/0/00", pass, diag_valid, fail_map);
    end
    wait_done(1'b0, done_cyc);
    n_checks++;
    if (done_cyc != 26) begin
      n_fail++; $display("FAIL asa0_latency done_cycle=%0d exp=26", done_cyc);
    end
    n_checks++;
    if (u_dut.resp_sig !== 16'hBCBC) begin
      n_fail++; $display("FAIL asa0_sig got=%h exp=BCBC", u_dut.resp_sig);
    end
    n_checks++;
    if ({pass, fail_map, err_count, diag_valid, fault_code} !== {1'b0, 8'hF0, 4'd4, 1'b1, 3'b100}) begin
      n_fail++; $display("FAIL asa0_result pass=%b map=%h err=%0d dv=%b code=%b exp 0/F0/4/1/100",
                         pass, fail_map, err_count, diag_valid, fault_code);
    end
  endtask

  // abort and start together while DONE: abort wins, results cleared.
  task automatic test_abort_in_done;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if ({busy, done, pass, diag_valid, fail_map, err_count, fault_code} !== 19'd0) begin
      n_fail++; $display("FAIL abort_done busy=%b done=%b map=%h err=%0d dv=%b code=%b exp all 0",
                         busy, done, fail_map, err_count, diag_valid, fault_code);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_priority busy=%b exp=0", busy);
    end
  endtask

  task automatic test_all_sa0;
    int done_cyc;
    force0 = 3'b111; bout_sa1 = 1'b0;
    pulse_start(1'b0);
    wait_done(1'b0, done_cyc);
    n_checks++;
    if ({pass, fail_map, err_count, diag_valid, fault_code} !== {1'b0, 8'h9E, 4'd5, 1'b1, 3'b111}) begin
      n_fail++; $display("FAIL allsa0_result cyc=%0d pass=%b map=%h err=%0d dv=%b code=%b exp 0/9E/5/1/111",
                         done_cyc, pass, fail_map, err_count, diag_valid, fault_code);
    end
  endtask

  task automatic test_bout_sa1;
    int done_cyc;
    force0 = 3'b000; bout_sa1 = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, done_cyc);
    n_checks++;
    if ({pass, fail_map, err_count, diag_valid, fault_code} !== {1'b0, 8'h71, 4'd4, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL boutsa1_result cyc=%0d pass=%b map=%h err=%0d dv=%b code=%b exp 0/71/4/0/000",
                         done_cyc, pass, fail_map, err_count, diag_valid, fault_code);
    end
    bout_sa1 = 1'b0;
  endtask

  task automatic test_stop_on_fail;
    int done_cyc;
    force0 = 3'b100; bout_sa1 = 1'b0;
    pulse_start(1'b1);
    wait_done(1'b1, done_cyc);
    // Vector 4 sampled in cycle 15, DIAG in 16, done in 17.
    n_checks++;
    if (done_cyc != 17) begin
      n_fail++; $display("FAIL sof_latency done_cycle=%0d exp=17", done_cyc);
    end
    n_checks++;
    if ({s_pass, s_fail_map, s_err_count, s_diag_valid, s_fault_code} !== {1'b0, 8'h10, 4'd1, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL sof_result pass=%b map=%h err=%0d dv=%b code=%b exp 0/10/1/0/000",
                         s_pass, s_fail_map, s_err_count, s_diag_valid, s_fault_code);
    end
    force0 = 3'b000;
  endtask

  task automatic test_rst_mid_sweep;
    bout_sa1 = 1'b1;
    pulse_start(1'b0);
    repeat (9) @(posedge clk);
    #1;
    // Cycle 10: vector 0 already failed, vector 3 on the pins.
    n_checks++;
    if ({fail_map, dut_a, dut_b, dut_bin} !== {8'h01, 3'b011}) begin
      n_fail++; $display("FAIL rst_pre map=%h pins=%b exp 01/011", fail_map, {dut_a, dut_b, dut_bin});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, fail_map, err_count, dut_a, dut_b, dut_bin} !== 17'd0) begin
      n_fail++; $display("FAIL rst_mid busy=%b done=%b map=%h err=%0d pins=%b exp all 0",
                         busy, done, fail_map, err_count, {dut_a, dut_b, dut_bin});
    end
    n_checks++;
    if (u_dut.resp_sig !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_sig got=%h exp=0000", u_dut.resp_sig);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bout_sa1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start_and_abort;
    int done_cyc;
    force0 = 3'b000; bout_sa1 = 1'b0;
    pulse_start(1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Cycle 6 is SAMPLE of vector 1 unless the extra start restarted the sweep.
    n_checks++;
    if ({dut_a, dut_b, dut_bin} !== 3'b001) begin
      n_fail++; $display("FAIL busy_start pins=%b exp=001", {dut_a, dut_b, dut_bin});
    end
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if ({busy, done, dut_a, dut_b, dut_bin, fail_map} !== 13'd0) begin
      n_fail++; $display("FAIL abort_mid busy=%b done=%b pins=%b map=%h exp all 0",
                         busy, done, {dut_a, dut_b, dut_bin}, fail_map);
    end
    pulse_start(1'b0);
    wait_done(1'b0, done_cyc);
    n_checks++;
    if (done_cyc != 26) begin
      n_fail++; $display("FAIL restart_latency done_cycle=%0d exp=26", done_cyc);
    end
    n_checks++;
    if ({pass, fail_map, err_count, diag_valid, fault_code} !== {1'b1, 8'h00, 4'd0, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL restart_result pass=%b map=%h err=%0d dv=%b code=%b exp 1/00/0/1/000",
                         pass, fail_map, err_count, diag_valid, fault_code);
    end
  endtask

  // Back-to-back from DONE: a failing sweep directly followed by a clean one.
  task automatic test_back_to_back;
    int done_cyc;
    force0 = 3'b010;
    pulse_start(1'b0);
    wait_done(1'b0, done_cyc);
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first pass=%b exp=0", pass);
    end
    force0 = 3'b000;
    pulse_start(1'b0);
    wait_done(1'b0, done_cyc);
    n_checks++;
    if ({done_cyc == 26, pass, fail_map, err_count} !== {1'b1, 1'b1, 8'h00, 4'd0}) begin
      n_fail++; $display("FAIL b2b_second cyc=%0d pass=%b map=%h err=%0d exp 26/1/00/0",
                         done_cyc, pass, fail_map, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_a_sa0();
    test_abort_in_done();
    test_all_sa0();
    test_bout_sa1();
    test_stop_on_fail();
    test_rst_mid_sweep();
    test_busy_start_and_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
